pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the MIPS fetch stage; it generalises the fixed 32-bit +1 incrementer into a registered PC with configurable width and step. It handles several next-PC sources: sequential step, PC-relative branch, absolute jump, and exception vector. It adds stall hold, a one-entry pending-redirect buffer, misalignment trapping and a valid/ready handshake toward instruction fetch.

---
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential step, relative/absolute redirect,
// exception vectoring, stall-time redirect buffering and misalignment trapping.
module pc_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STEP         = 4,
  parameter int unsigned ALIGN_BITS   = 2,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic             redirect_kind,
  input  logic [WIDTH-1:0] redirect_value,
  input  logic             exc_req,
  output logic [WIDTH-1:0] epc,
  output logic             misalign,
  output logic             redirect_pending
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_TRAP} state_t;

  localparam logic [WIDTH-1:0] L_RESET_PC   = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] L_EXC_PC     = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] L_STEP       = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] L_ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_misalign;
  logic             r_fetch_valid;
  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pend_target;

  logic [WIDTH-1:0] w_pc_plus_step;
  logic [WIDTH-1:0] w_target;
  logic             w_misaligned;
  logic             w_trap;
  logic             w_step;

  assign w_pc_plus_step = r_pc + L_STEP;
  // Relative offsets are in instruction words, measured from the next sequential pc.
  assign w_target       = redirect_kind ? redirect_value
                                        : w_pc_plus_step + (redirect_value << ALIGN_BITS);
  assign w_misaligned   = redirect_kind && ((w_target & L_ALIGN_MASK) != '0);
  assign w_trap         = exc_req || (redirect_valid && w_misaligned);
  assign w_step         = (r_state == ST_RUN) && r_fetch_valid && fetch_ready && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= L_RESET_PC;
      r_epc         <= '0;
      r_misalign    <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_pend_valid  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (exc_req) begin
        r_pc         <= L_EXC_PC;
        r_epc        <= r_pc;
        r_pend_valid <= 1'b0;
      end else if (redirect_valid && w_misaligned) begin
        r_pc         <= L_EXC_PC;
        r_epc        <= w_target;
        r_misalign   <= 1'b1;
        r_pend_valid <= 1'b0;
      end else if (redirect_valid && stall) begin
        r_pend_valid <= 1'b1;
      end else if (redirect_valid) begin
        r_pc         <= w_target;
        r_pend_valid <= 1'b0;
      end else if (r_pend_valid && !stall) begin
        r_pc         <= r_pend_target;
        r_pend_valid <= 1'b0;
      end else if (w_step) begin
        r_pc <= w_pc_plus_step;
      end

      // BOOT and TRAP are single-cycle bubbles; any trap re-enters TRAP.
      if (w_trap) begin
        r_state       <= ST_TRAP;
        r_fetch_valid <= 1'b0;
      end else begin
        r_state       <= ST_RUN;
        r_fetch_valid <= 1'b1;
      end
    end
  end

  // Pending target is datapath only; its valid bit gates every use.
  always_ff @(posedge clk) begin
    if (redirect_valid && stall && !w_trap) begin
      r_pend_target <= w_target;
    end
  end

  assign pc               = r_pc;
  assign pc_plus_step     = w_pc_plus_step;
  assign fetch_valid      = r_fetch_valid;
  assign epc              = r_epc;
  assign misalign         = r_misalign;
  assign redirect_pending = r_pend_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a behavioural model,
// plus an 8-bit instance for wrap-around.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        redirect_kind = 1'b0;
  logic [31:0] redirect_value = '0;
  logic        exc_req = 1'b0;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic [31:0] epc;
  logic        misalign;
  logic        redirect_pending;

  logic        s_ready = 1'b0;
  logic        s_rv = 1'b0;
  logic        s_kind = 1'b0;
  logic [7:0]  s_value = '0;
  logic        s_fv;
  logic [7:0]  s_pc;
  logic [7:0]  s_pps;
  logic [7:0]  s_epc;
  logic        s_mis;
  logic        s_pend;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  longint m_pc, m_epc, m_ptgt;
  bit     m_run, m_pend, m_mis;
  localparam longint M = 64'h1_0000_0000;
  localparam longint EXC = 64'h8000_0180;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .pc(pc), .pc_plus_step(pc_plus_step), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_kind(redirect_kind), .redirect_value(redirect_value), .exc_req(exc_req),
    .epc(epc), .misalign(misalign), .redirect_pending(redirect_pending)
  );

  pc_sequencer #(.WIDTH(8), .STEP(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .fetch_ready(s_ready), .fetch_valid(s_fv),
    .pc(s_pc), .pc_plus_step(s_pps), .stall(1'b0), .redirect_valid(s_rv),
    .redirect_kind(s_kind), .redirect_value(s_value), .exc_req(1'b0),
    .epc(s_epc), .misalign(s_mis), .redirect_pending(s_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'hBFC0_0000; m_epc = 0; m_ptgt = 0;
    m_run = 0; m_pend = 0; m_mis = 0;
  endtask

  // Applies the next-pc rules to the model for the coming clock edge.
  task automatic model_edge();
    longint tgt;
    bit     bad, trapped, was_run;
    was_run = m_run;
    if (redirect_kind) tgt = longint'(redirect_value);
    else begin
      tgt = m_pc + 4 + 4 * longint'($signed(redirect_value));
      tgt = tgt % M;
      if (tgt < 0) tgt = tgt + M;
    end
    bad = redirect_kind && (tgt % 4 != 0);
    trapped = 0;
    m_mis = 0;
    if (exc_req) begin
      m_epc = m_pc; m_pc = EXC; m_pend = 0; trapped = 1;
    end else if (redirect_valid && bad) begin
      m_epc = tgt; m_pc = EXC; m_pend = 0; m_mis = 1; trapped = 1;
    end else if (redirect_valid && stall) begin
      m_pend = 1; m_ptgt = tgt;
    end else if (redirect_valid) begin
      m_pc = tgt; m_pend = 0;
    end else if (m_pend && !stall) begin
      m_pc = m_ptgt; m_pend = 0;
    end else if (was_run && fetch_ready && !stall) begin
      m_pc = (m_pc + 4) % M;
    end
    m_run = !trapped;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"}, {32'b0, pc}, m_pc);
    chk({tag, ".pps"}, {32'b0, pc_plus_step}, (m_pc + 4) % M);
    chk({tag, ".fv"}, {63'b0, fetch_valid}, {63'b0, m_run});
    chk({tag, ".epc"}, {32'b0, epc}, m_epc);
    chk({tag, ".mis"}, {63'b0, misalign}, {63'b0, m_mis});
    chk({tag, ".pend"}, {63'b0, redirect_pending}, {63'b0, m_pend});
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic abs_jump(input logic [31:0] t);
    redirect_valid = 1; redirect_kind = 1; redirect_value = t;
    tick("jump");
    redirect_valid = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
    fetch_ready = 1'b1;

    // Boot: one bubble then stepping
    tick("boot0");
    chk("boot_pc0", {32'b0, pc}, 64'hBFC0_0000);
    tick("boot1");
    tick("boot2");
    tick("boot3");
    chk("boot_pc3", {32'b0, pc}, 64'hBFC0_000C);

    // Ready low holds pc
    abs_jump(32'h100);
    fetch_ready = 0;
    repeat (4) tick("hold");
    chk("hold_pc", {32'b0, pc}, 64'h100);
    chk("hold_fv", {63'b0, fetch_valid}, 64'h1);
    fetch_ready = 1;
    tick("resume");
    chk("resume_pc", {32'b0, pc}, 64'h104);

    // Relative redirect backward
    abs_jump(32'h200);
    redirect_valid = 1; redirect_kind = 0; redirect_value = -32'sd2;
    tick("rel_neg");
    redirect_valid = 0;
    chk("rel_neg_pc", {32'b0, pc}, 64'h1FC);

    // Relative redirect buffered under stall
    abs_jump(32'h200);
    stall = 1;
    redirect_valid = 1; redirect_kind = 0; redirect_value = 32'd5;
    tick("pend_cap");
    redirect_valid = 0;
    chk("pend_set", {63'b0, redirect_pending}, 64'h1);
    chk("pend_hold", {32'b0, pc}, 64'h200);
    repeat (2) tick("pend_wait");
    stall = 0;
    tick("pend_rel");
    chk("pend_pc", {32'b0, pc}, 64'h218);
    chk("pend_clr", {63'b0, redirect_pending}, 64'h0);

    // Misaligned absolute target traps
    abs_jump(32'h300);
    redirect_valid = 1; redirect_kind = 1; redirect_value = 32'h1002;
    tick("mis");
    redirect_valid = 0;
    chk("mis_pulse", {63'b0, misalign}, 64'h1);
    chk("mis_pc", {32'b0, pc}, 64'h8000_0180);
    chk("mis_epc", {32'b0, epc}, 64'h1002);
    chk("mis_fv", {63'b0, fetch_valid}, 64'h0);
    tick("mis_after");
    chk("mis_fv_back", {63'b0, fetch_valid}, 64'h1);

    // Exception beats coincident stalled redirect
    abs_jump(32'h400);
    stall = 1;
    redirect_valid = 1; redirect_kind = 0; redirect_value = 32'd3;
    tick("exc_pre");
    exc_req = 1;
    tick("exc");
    exc_req = 0; redirect_valid = 0; stall = 0;
    chk("exc_pc", {32'b0, pc}, 64'h8000_0180);
    chk("exc_epc", {32'b0, epc}, 64'h400);
    chk("exc_pend", {63'b0, redirect_pending}, 64'h0);

    // 8-bit wrap-around
    s_rv = 1; s_kind = 1; s_value = 8'hFC;
    tick("w8_jump");
    s_rv = 0; s_ready = 1;
    chk("w8_pc", {56'b0, s_pc}, 64'hFC);
    chk("w8_pps", {56'b0, s_pps}, 64'h00);
    tick("w8_step");
    chk("w8_wrap", {56'b0, s_pc}, 64'h00);
    s_ready = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      redirect_valid = ($urandom % 4) == 0;
      redirect_kind  = $urandom % 2;
      if (redirect_kind)
        redirect_value = ($urandom & 32'hFFFF_FFFC) | ((($urandom % 8) == 0) ? 32'd2 : 32'd0);
      else
        redirect_value = 32'($signed($urandom_range(0, 64)) - 32);
      exc_req     = ($urandom % 32) == 0;
      stall       = ($urandom % 4) == 0;
      fetch_ready = ($urandom % 4) != 0;
      tick("rand");
    end

    // Asynchronous reset with a pending redirect
    exc_req = 0; stall = 1;
    redirect_valid = 1; redirect_kind = 1; redirect_value = 32'h500;
    tick("arst_pre");
    redirect_valid = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_model("arst");
    @(posedge clk);
    #1 rst_n = 1;
    stall = 0;
    tick("arst_boot");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
